key_input_ctrl: RTL and testbench

KEY_INPUT_CTRL -- requirements
Module: key_input_ctrl

---
 rtl/key_input_ctrl_if.sv | 13 +
 rtl/key_input_ctrl.sv | 167 ++++++++++++++++
 tb/tb_key_input_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/key_input_ctrl_if.sv
// Bus bundle for key_input_ctrl: raw key/switch inputs and debounced event outputs.
interface key_input_ctrl_if;
    logic [1:0] key_n;
    logic [9:0] sw;
    logic [1:0] press;
    logic [1:0] rpt;
    logic [1:0] key_level;
    logic [1:0] mode;
    logic [9:0] sw_q;

    modport master (output key_n, sw, input press, rpt, key_level, mode, sw_q);
    modport slave  (input key_n, sw, output press, rpt, key_level, mode, sw_q);
endinterface

// File: rtl/key_input_ctrl.sv
// key_input_ctrl: two debounced push-buttons with press pulses, mode toggles and a switch snapshot.
// Auto-repeat pulses on rpt are built only when KEY_AUTOREPEAT_EN is defined.
module key_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 1000000
) (
    input logic             ADC_CLK_10,
    input logic             rst,
    key_input_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_e;

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("key_input_ctrl: timing parameters must be at least 1");
    end

    logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0] pk;
    logic [1:0] press_v, rpt_v, level_v;
    logic [1:0] mode_q, mode_d;
    logic [9:0] snap_q, snap_d;

    always_comb begin
        sync1_d = bus.key_n;
        sync2_d = sync1_q;
        pk      = ~sync2_q;
        mode_d  = mode_q ^ press_v;
        snap_d  = (|press_v) ? bus.sw : snap_q;
    end

    // Synchronizers reset to the released (high) level so a held key debounces normally.
    always_ff @(posedge ADC_CLK_10 or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            mode_q  <= 2'b00;
            snap_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            mode_q  <= mode_d;
            snap_q  <= snap_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_key
        key_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             press_q, press_d;
        logic             level_q, level_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (pk[g]) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pk[g]) begin
                        state_d = IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = HELD;
                        press_d = 1'b1;
                    end else if (cnt_q != DB_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!pk[g]) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pk[g]) begin
                        state_d = HELD;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = IDLE;
                    end else if (cnt_q != DB_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        end

        always_ff @(posedge ADC_CLK_10 or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                press_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
                level_q <= level_d;
            end
        end

        assign press_v[g] = press_q;
        assign level_v[g] = level_q;

`ifdef KEY_AUTOREPEAT_EN
        localparam int RPT_TOP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RPT_W   = $clog2(RPT_TOP + 1);
        localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
        localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);
        localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(RPT_TOP);

        logic [RPT_W-1:0] rcnt_q, rcnt_d;
        logic             rfirst_q, rfirst_d;
        logic             rpt_q, rpt_d;

        // Counting only while HELD persists; any exit or entry restarts the initial delay.
        always_comb begin
            rcnt_d   = '0;
            rfirst_d = 1'b1;
            rpt_d    = 1'b0;
            if (state_q == HELD && state_d == HELD) begin
                rfirst_d = rfirst_q;
                rcnt_d   = rcnt_q;
                if (rcnt_q == (rfirst_q ? RD_LAST : RP_LAST)) begin
                    rpt_d    = 1'b1;
                    rcnt_d   = '0;
                    rfirst_d = 1'b0;
                end else if (rcnt_q != RPT_MAX) begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge ADC_CLK_10 or posedge rst) begin
            if (rst) begin
                rcnt_q   <= '0;
                rfirst_q <= 1'b1;
                rpt_q    <= 1'b0;
            end else begin
                rcnt_q   <= rcnt_d;
                rfirst_q <= rfirst_d;
                rpt_q    <= rpt_d;
            end
        end

        assign rpt_v[g] = rpt_q;
`else
        assign rpt_v[g] = 1'b0;
`endif
    end

    assign bus.press     = press_v;
    assign bus.rpt       = rpt_v;
    assign bus.key_level = level_v;
    assign bus.mode      = mode_q;
    assign bus.sw_q      = snap_q;
endmodule

// File: tb/tb_key_input_ctrl.sv
// Scoreboard bench for key_input_ctrl with short debounce/repeat timing.
module tb_key_input_ctrl;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int LAT = DB + 3;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR_EN = 1'b1;
`else
    localparam bit AR_EN = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } press_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   rpt_seen = 0;
    int   rpt_total_exp = 0;
    logic [1:0] exp_mode = 2'b00;
    int   c, r;

    press_ev_t press_exp[$];
    int        rpt_exp[$];

    key_input_ctrl_if bus ();

    key_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .ADC_CLK_10(clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_press(input int at, input logic [1:0] keys);
        press_ev_t ev;
        ev.cyc = at;
        ev.val = keys;
        press_exp.push_back(ev);
        exp_mode = exp_mode ^ keys;
    endtask

    // p: edge that entered HELD; leave: edge that moves to RELEASE_WAIT
    task automatic push_rpt(input int p, input int leave);
        for (int e = p + RD; e < leave; e += RP) begin
            if (AR_EN) begin
                rpt_exp.push_back(e);
                rpt_total_exp = rpt_total_exp + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.press !== 2'b00) begin
            if (press_exp.size() == 0) begin
                check_val("press_unexpected", {30'd0, bus.press}, 32'd0);
            end else begin
                press_ev_t ev;
                ev = press_exp.pop_front();
                check_val("press_cycle", cyc, ev.cyc);
                check_val("press_keys", {30'd0, bus.press}, {30'd0, ev.val});
            end
        end
        if (bus.rpt !== 2'b00) begin
            rpt_seen = rpt_seen + 1;
            if (rpt_exp.size() == 0) begin
                check_val("rpt_unexpected", {30'd0, bus.rpt}, 32'd0);
            end else begin
                int e;
                e = rpt_exp.pop_front();
                check_val("rpt_cycle", cyc, e);
                check_val("rpt_keys", {30'd0, bus.rpt}, 32'd1);
            end
        end
    end

    initial begin
        bus.key_n = 2'b11;
        bus.sw    = 10'h000;
        rst       = 1'b1;
        step(3);
        check_val("rst_press", {30'd0, bus.press}, 32'd0);
        check_val("rst_rpt", {30'd0, bus.rpt}, 32'd0);
        check_val("rst_level", {30'd0, bus.key_level}, 32'd0);
        check_val("rst_mode", {30'd0, bus.mode}, 32'd0);
        check_val("rst_swq", {22'd0, bus.sw_q}, 32'd0);
        rst = 1'b0;

        // Key 0 held 50 cycles, then released
        step(2);
        c = cyc;
        bus.key_n[0] = 1'b0;
        push_press(c + LAT, 2'b01);
        step(6);
        check_val("k0_level_before", {30'd0, bus.key_level}, 32'd0);
        step(2);
        check_val("k0_level_held", {30'd0, bus.key_level}, 32'd1);
        check_val("k0_mode", {30'd0, bus.mode}, {30'd0, exp_mode});
        step(42);
        bus.key_n[0] = 1'b1;
        push_rpt(c + LAT, c + 53);
        step(6);
        check_val("k0_level_release_wait", {30'd0, bus.key_level}, 32'd1);
        step(1);
        check_val("k0_level_released", {30'd0, bus.key_level}, 32'd0);
        step(5);
        check_val("k0_pending", press_exp.size(), 32'd0);

        // Key 1 bounce too short to debounce
        bus.key_n[1] = 1'b0;
        step(2);
        bus.key_n[1] = 1'b1;
        step(1);
        bus.key_n[1] = 1'b0;
        step(2);
        bus.key_n[1] = 1'b1;
        step(12);
        check_val("bounce_mode", {30'd0, bus.mode}, {30'd0, exp_mode});
        check_val("bounce_level", {30'd0, bus.key_level}, 32'd0);

        // Switch snapshot on key 0 press
        bus.sw = 10'h2A5;
        c = cyc;
        bus.key_n[0] = 1'b0;
        push_press(c + LAT, 2'b01);
        step(8);
        check_val("snap_load", {22'd0, bus.sw_q}, 32'h2A5);
        bus.sw = 10'h000;
        step(5);
        check_val("snap_hold", {22'd0, bus.sw_q}, 32'h2A5);
        check_val("snap_mode", {30'd0, bus.mode}, {30'd0, exp_mode});
        bus.key_n[0] = 1'b1;
        step(10);

        // Both keys together
        bus.sw = 10'h3FF;
        c = cyc;
        bus.key_n = 2'b00;
        push_press(c + LAT, 2'b11);
        step(8);
        check_val("both_mode", {30'd0, bus.mode}, {30'd0, exp_mode});
        check_val("both_swq", {22'd0, bus.sw_q}, 32'h3FF);
        check_val("both_level", {30'd0, bus.key_level}, 32'd3);
        bus.key_n = 2'b11;
        step(10);
        check_val("both_released", {30'd0, bus.key_level}, 32'd0);

        // Long hold: auto-repeat when enabled, none otherwise
        c = cyc;
        bus.key_n[0] = 1'b0;
        push_press(c + LAT, 2'b01);
        step(67);
        bus.key_n[0] = 1'b1;
        push_rpt(c + LAT, c + 70);
        step(10);
        check_val("hold_mode", {30'd0, bus.mode}, {30'd0, exp_mode});
        check_val("hold_rpt_count", rpt_seen, rpt_total_exp);
        check_val("hold_rpt_pending", rpt_exp.size(), 32'd0);

        // Reset while in PRESS_WAIT with the key kept low
        bus.key_n[0] = 1'b0;
        step(5);
        rst = 1'b1;
        #1;
        check_val("midrst_mode", {30'd0, bus.mode}, 32'd0);
        check_val("midrst_swq", {22'd0, bus.sw_q}, 32'd0);
        check_val("midrst_level", {30'd0, bus.key_level}, 32'd0);
        check_val("midrst_press", {30'd0, bus.press}, 32'd0);
        exp_mode = 2'b00;
        step(2);
        rst = 1'b0;
        r = cyc;
        push_press(r + LAT, 2'b01);
        step(10);
        check_val("postrst_mode", {30'd0, bus.mode}, {30'd0, exp_mode});
        check_val("postrst_swq", {22'd0, bus.sw_q}, 32'h3FF);
        bus.key_n[0] = 1'b1;
        step(10);

        check_val("final_press_pending", press_exp.size(), 32'd0);
        check_val("final_rpt_pending", rpt_exp.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
